// File: rtl/vga_sram_responder.sv
// SRAM arbiter on the pixel clock: VGA scan-out reads have absolute priority,
// single-byte CPU strobe/ack accesses fill the remaining SRAM cycles.
module vga_sram_responder #(
   parameter int unsigned ADR_WIDTH = 19
) (
   input  logic                 I_vga_clk,
   input  logic                 I_reset,
   input  logic                 I_vga_req,
   input  logic [ADR_WIDTH-1:0] I_vga_adr,
   output logic [7:0]           O_vga_dat,
   input  logic                 I_cpu_stb,
   input  logic                 I_cpu_we,
   input  logic [ADR_WIDTH-1:0] I_cpu_adr,
   input  logic [7:0]           I_cpu_dat,
   output logic                 O_cpu_ack,
   output logic [7:0]           O_cpu_dat,
   output logic [ADR_WIDTH-1:0] O_sram_adr,
   output logic [7:0]           O_sram_dat,
   output logic                 O_sram_dat_oe,
   input  logic [7:0]           I_sram_dat,
   output logic                 O_sram_oe_n,
   output logic                 O_sram_we_n,
   output logic                 O_sram_ce_n
);

   typedef enum logic [1:0] {
      IDLE,
      VGA_RD,
      CPU_RD,
      CPU_WR
   } state_t;

   state_t               state, state_nx;
   logic [ADR_WIDTH-1:0] sram_adr_nx;
   logic [7:0]           sram_dat_nx;
   logic                 dat_oe_nx, oe_n_nx, we_n_nx;
   logic [7:0]           vga_hold, vga_hold_nx;
   logic [7:0]           cpu_dat_nx;
   logic                 cpu_ack_nx;
   logic                 cpu_done, cpu_done_nx;
   logic                 cpu_busy;

   always_comb begin
      // The access in flight counts as done already; cpu_done only turns on
      // at the edge that ends it, which would otherwise relaunch the same stb.
      cpu_busy = cpu_done || (state == CPU_RD) || (state == CPU_WR);

      state_nx    = IDLE;
      sram_adr_nx = O_sram_adr;
      sram_dat_nx = O_sram_dat;
      dat_oe_nx   = 1'b0;
      oe_n_nx     = 1'b1;
      we_n_nx     = 1'b1;

      if (I_vga_req) begin
         state_nx    = VGA_RD;
         sram_adr_nx = I_vga_adr;
         oe_n_nx     = 1'b0;
      end else if (I_cpu_stb && !cpu_busy) begin
         sram_adr_nx = I_cpu_adr;
         if (I_cpu_we) begin
            state_nx    = CPU_WR;
            sram_dat_nx = I_cpu_dat;
            dat_oe_nx   = 1'b1;
            we_n_nx     = 1'b0;
         end else begin
            state_nx = CPU_RD;
            oe_n_nx  = 1'b0;
         end
      end

      vga_hold_nx = vga_hold;
      cpu_dat_nx  = O_cpu_dat;
      cpu_ack_nx  = 1'b0;
      cpu_done_nx = I_cpu_stb ? cpu_done : 1'b0;

      case (state)
         VGA_RD: vga_hold_nx = I_sram_dat;
         CPU_RD: begin
            cpu_dat_nx  = I_sram_dat;
            cpu_ack_nx  = 1'b1;
            cpu_done_nx = I_cpu_stb;
         end
         CPU_WR: begin
            cpu_ack_nx  = 1'b1;
            cpu_done_nx = I_cpu_stb;
         end
         default: ;
      endcase
   end

   always_ff @(posedge I_vga_clk) begin
      if (I_reset) begin
         state         <= IDLE;
         O_sram_adr    <= '0;
         O_sram_dat    <= '0;
         O_sram_dat_oe <= 1'b0;
         O_sram_oe_n   <= 1'b1;
         O_sram_we_n   <= 1'b1;
         O_sram_ce_n   <= 1'b1;
         vga_hold      <= '0;
         O_cpu_ack     <= 1'b0;
         O_cpu_dat     <= '0;
         cpu_done      <= 1'b0;
      end else begin
         state         <= state_nx;
         O_sram_adr    <= sram_adr_nx;
         O_sram_dat    <= sram_dat_nx;
         O_sram_dat_oe <= dat_oe_nx;
         O_sram_oe_n   <= oe_n_nx;
         O_sram_we_n   <= we_n_nx;
         O_sram_ce_n   <= 1'b0;
         vga_hold      <= vga_hold_nx;
         O_cpu_ack     <= cpu_ack_nx;
         O_cpu_dat     <= cpu_dat_nx;
         cpu_done      <= cpu_done_nx;
      end
   end

   assign O_vga_dat = (state == VGA_RD) ? I_sram_dat : vga_hold;

endmodule

// File: tb/tb_vga_sram_responder.sv
// Scoreboard bench for vga_sram_responder with a behavioural asynchronous SRAM.
module tb_vga_sram_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vga_req = 1'b0;
   logic [18:0] vga_adr = '0;
   logic [7:0]  vga_dat;
   logic        cpu_stb = 1'b0;
   logic        cpu_we = 1'b0;
   logic [18:0] cpu_adr = '0;
   logic [7:0]  cpu_wdat = '0;
   logic        cpu_ack;
   logic [7:0]  cpu_rdat;
   logic [18:0] sram_adr;
   logic [7:0]  sram_wdat;
   logic        sram_dat_oe;
   logic [7:0]  sram_q;
   logic        sram_oe_n, sram_we_n, sram_ce_n;

   vga_sram_responder #(.ADR_WIDTH(19)) dut (
      .I_vga_clk    (clk),
      .I_reset      (rst),
      .I_vga_req    (vga_req),
      .I_vga_adr    (vga_adr),
      .O_vga_dat    (vga_dat),
      .I_cpu_stb    (cpu_stb),
      .I_cpu_we     (cpu_we),
      .I_cpu_adr    (cpu_adr),
      .I_cpu_dat    (cpu_wdat),
      .O_cpu_ack    (cpu_ack),
      .O_cpu_dat    (cpu_rdat),
      .O_sram_adr   (sram_adr),
      .O_sram_dat   (sram_wdat),
      .O_sram_dat_oe(sram_dat_oe),
      .I_sram_dat   (sram_q),
      .O_sram_oe_n  (sram_oe_n),
      .O_sram_we_n  (sram_we_n),
      .O_sram_ce_n  (sram_ce_n)
   );

   always #20 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] pat(input logic [18:0] a);
      return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
   endfunction

   // SRAM model: contents start as pat(), writes land at the end of a we_n-low cycle
   logic [7:0]  mem [0:(1<<19)-1];
   bit          mem_init = 1'b0;
   logic        pre_we = 1'b0;
   logic [18:0] pre_adr = '0;
   logic [7:0]  pre_dat = '0;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < (1 << 19); i++) mem[i] = pat(19'(i));
         mem_init = 1'b1;
      end
      if (pre_we) mem[pre_adr] = pre_dat;
      else if (!sram_ce_n && !sram_we_n) mem[sram_adr] = sram_wdat;
   end

   assign sram_q = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr] : 8'h00;

   // reference contents, independent of the model array
   logic [7:0] ref_wr [int unsigned];

   function automatic logic [7:0] exp_rd(input logic [18:0] a);
      return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : pat(a);
   endfunction

   typedef struct packed {
      logic       we;
      logic [7:0] dat;
   } cpu_exp_t;

   logic [7:0] vga_q [$];
   cpu_exp_t   cpu_q [$];

   bit         mon_en = 1'b0;
   logic       vga_pend = 1'b0;
   logic       rst_q = 1'b1;
   logic [7:0] vga_last = '0;
   int         wr_cycles = 0;
   int         acc_cycles = 0;
   int         ack_cnt = 0;
   bit         vga_done = 1'b0;

   always @(posedge clk) begin
      vga_pend <= vga_req & ~rst;
      rst_q    <= rst;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (!sram_we_n) wr_cycles++;
         if (!sram_oe_n || !sram_we_n) acc_cycles++;
         if (rst_q) begin
            vga_last = 8'h00;
         end else if (vga_pend) begin
            if (vga_q.size() == 0) begin
               chk("vga_unexpected", 32'(vga_dat), 32'hFFFF_FFFF);
            end else begin
               vga_last = vga_q.pop_front();
               chk("vga_dat", 32'(vga_dat), 32'(vga_last));
            end
         end else begin
            chk("vga_hold", 32'(vga_dat), 32'(vga_last));
         end
         if (cpu_ack) begin
            cpu_exp_t e;
            ack_cnt++;
            if (cpu_q.size() == 0) begin
               chk("cpu_unexpected_ack", 32'(cpu_ack), 32'd0);
            end else begin
               e = cpu_q.pop_front();
               if (!e.we) chk("cpu_rdat", 32'(cpu_rdat), 32'(e.dat));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic vga_pulse(input logic [18:0] adr);
      vga_req = 1'b1;
      vga_adr = adr;
      vga_q.push_back(exp_rd(adr));
      tick();
      vga_req = 1'b0;
   endtask

   task automatic cpu_access(input logic we, input logic [18:0] adr, input logic [7:0] dat,
                             input int unsigned hold, output int unsigned lat);
      cpu_exp_t e;
      e.we  = we;
      e.dat = we ? 8'h00 : exp_rd(adr);
      if (we) ref_wr[int'(adr)] = dat;
      cpu_q.push_back(e);
      cpu_stb  = 1'b1;
      cpu_we   = we;
      cpu_adr  = adr;
      cpu_wdat = dat;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!cpu_ack && lat < 20);
      if (!cpu_ack) chk("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
      repeat (hold) tick();
      cpu_stb = 1'b0;
      tick();
   endtask

   task automatic preload(input logic [18:0] a, input logic [7:0] d);
      pre_adr = a;
      pre_dat = d;
      pre_we  = 1'b1;
      ref_wr[int'(a)] = d;
      tick();
      pre_we = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned lat;
      int w0, a0, k0;

      repeat (3) tick();
      chk("rst_sram_adr", 32'(sram_adr), 32'd0);
      chk("rst_sram_dat", 32'(sram_wdat), 32'd0);
      chk("rst_dat_oe", 32'(sram_dat_oe), 32'd0);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
      chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("rst_cpu_dat", 32'(cpu_rdat), 32'd0);
      chk("rst_vga_dat", 32'(vga_dat), 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      tick();
      chk("run_ce_n", 32'(sram_ce_n), 32'd0);

      // VGA read of a preloaded byte, then held
      preload(19'h20000, 8'hA5);
      vga_pulse(19'h20000);
      repeat (4) tick();

      // CPU write then read back
      w0 = wr_cycles;
      k0 = ack_cnt;
      cpu_access(1'b1, 19'h40001, 8'h3C, 0, lat);
      chk("wr_lat", lat, 32'd2);
      tick();
      chk("wr_we_cycles", 32'(wr_cycles - w0), 32'd1);
      chk("wr_acks", 32'(ack_cnt - k0), 32'd1);
      cpu_access(1'b0, 19'h40001, 8'h00, 0, lat);
      chk("rd_lat", lat, 32'd2);
      chk("rd_dat_held", 32'(cpu_rdat), 32'h3C);

      // VGA and CPU in the same cycle
      fork
         vga_pulse(19'h00123);
         cpu_access(1'b0, 19'h40001, 8'h00, 0, lat);
      join
      chk("collision_lat", lat, 32'd3);
      tick();

      // stb held after ack
      a0 = acc_cycles;
      k0 = ack_cnt;
      cpu_access(1'b0, 19'h40010, 8'h00, 5, lat);
      tick();
      chk("held_accesses", 32'(acc_cycles - a0), 32'd1);
      chk("held_acks", 32'(ack_cnt - k0), 32'd1);
      chk("held_rdat", 32'(cpu_rdat), 32'(pat(19'h40010)));

      // scan-out load with a busy CPU master
      fork
         begin
            for (int i = 0; i < 640; i++) begin
               if (i % 2 == 0) vga_pulse(19'($urandom_range(0, 16'hFFFF)));
               else tick();
            end
            vga_done = 1'b1;
         end
         begin
            while (!vga_done) begin
               logic        we;
               logic [18:0] a;
               logic [7:0]  d;
               we = 1'($urandom_range(0, 1));
               a  = 19'h40000 + 19'($urandom_range(0, 15));
               d  = 8'($urandom_range(0, 255));
               cpu_access(we, a, d, 0, lat);
               chk("load_lat", (lat <= 3) ? 32'd1 : 32'd0, 32'd1);
            end
         end
      join
      repeat (2) tick();

      // reset in the middle of a write cycle
      k0 = ack_cnt;
      cpu_stb  = 1'b1;
      cpu_we   = 1'b1;
      cpu_adr  = 19'h40020;
      cpu_wdat = 8'h77;
      tick();
      chk("abort_we_active", 32'(sram_we_n), 32'd0);
      rst = 1'b1;
      cpu_stb = 1'b0;
      tick();
      chk("abort_we_n", 32'(sram_we_n), 32'd1);
      chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
      chk("abort_ce_n", 32'(sram_ce_n), 32'd1);
      chk("abort_dat_oe", 32'(sram_dat_oe), 32'd0);
      chk("abort_ack", 32'(cpu_ack), 32'd0);
      rst = 1'b0;
      repeat (2) tick();
      chk("abort_no_ack", 32'(ack_cnt - k0), 32'd0);
      chk("resume_ce_n", 32'(sram_ce_n), 32'd0);
      cpu_access(1'b0, 19'h40001, 8'h00, 0, lat);
      chk("resume_lat", lat, 32'd2);
      vga_pulse(19'h20000);
      repeat (3) tick();

      chk("vga_q_drained", 32'(vga_q.size()), 32'd0);
      chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_sram_responder.md
# vga_sram_responder

Single-clock responder for the external 512 KiB asynchronous SRAM, running on the pixel clock. It serves the VGA scan-out read requests (req/address strobe, data returned in the following cycle) with absolute priority. It interleaves single-byte CPU read/write accesses, arriving over a classic strobe/ack port, into the free SRAM cycles. A separate clock-domain bridge on the CPU side feeds the CPU port in the I_vga_clk domain.

## Interface
- ADR_WIDTH, 19, SRAM byte address width

Ports:
- I_vga_clk  in  1  pixel clock; all logic on rising edge
- I_reset  in  1  synchronous, active-high reset
- I_vga_req  in  1  VGA read request, one-cycle pulse
- I_vga_adr  in  ADR_WIDTH  VGA read address, valid with I_vga_req
- O_vga_dat  out  8  VGA read data
- I_cpu_stb  in  1  CPU access request, held until O_cpu_ack
- I_cpu_we  in  1  1 = write, 0 = read; valid with I_cpu_stb
- I_cpu_adr  in  ADR_WIDTH  CPU address
- I_cpu_dat  in  8  CPU write data
- O_cpu_ack  out  1  one-cycle completion pulse
- O_cpu_dat  out  8  CPU read data, valid with O_cpu_ack and held afterwards
- O_sram_adr  out  ADR_WIDTH  SRAM address (registered)
- O_sram_dat  out  8  SRAM write data (registered)
- O_sram_dat_oe  out  1  pad output enable for O_sram_dat
- I_sram_dat  in  8  SRAM data pad input
- O_sram_oe_n  out  1  SRAM output enable, active low
- O_sram_we_n  out  1  SRAM write enable, active low
- O_sram_ce_n  out  1  SRAM chip enable, active low

## Operation
- States: IDLE, VGA_RD, CPU_RD, CPU_WR. Each non-IDLE state lasts exactly one cycle, and that cycle is one SRAM access.
- Next-state decision is made at every edge, evaluated in priority order:
  1. I_vga_req=1 -> VGA_RD. Load O_sram_adr<=I_vga_adr, oe_n=0, we_n=1, dat_oe=0.
  2. Else if I_cpu_stb=1 and cpu_done=0 -> CPU_RD or CPU_WR per I_cpu_we. Load O_sram_adr<=I_cpu_adr.
     - Read: oe_n=0.
     - Write: O_sram_dat<=I_cpu_dat, dat_oe=1, we_n=0, oe_n=1.
  3. Else -> IDLE. oe_n=1, we_n=1, dat_oe=0; O_sram_adr holds its value.
- The decision applies from any state, so back-to-back VGA_RD every cycle is legal.
- VGA data path:
  - While in VGA_RD, O_vga_dat = I_sram_dat (combinational pass-through).
  - At the edge leaving VGA_RD, I_sram_dat is captured into vga_hold.
  - In all other states, O_vga_dat = vga_hold.
- CPU completion:
  - At the edge leaving CPU_RD: O_cpu_dat<=I_sram_dat and O_cpu_ack<=1.
  - At the edge leaving CPU_WR: O_cpu_ack<=1.
  - O_cpu_ack is high for exactly one cycle.
- cpu_done flag:
  - Set together with O_cpu_ack.
  - Cleared at any edge where I_cpu_stb=0.
  - Prevents re-executing an access whose stb the master has not yet dropped.
- A CPU access is never aborted once launched. VGA only takes cycles not already committed, and since each access is one cycle, VGA waits at most 0 cycles.
- CPU starvation is permitted while VGA requests every cycle. The scan-out reader requests at most every other cycle, which bounds CPU latency to 2 cycles during active video.
- O_sram_ce_n = 0 whenever not in reset.
- Reset values:
  - O_sram_adr=0, O_sram_dat=0, O_sram_dat_oe=0, O_sram_oe_n=1, O_sram_we_n=1, O_sram_ce_n=1
  - O_vga_dat/vga_hold=0, O_cpu_ack=0, O_cpu_dat=0
  - state=IDLE, cpu_done=0
- Reset mid-access: the access is dropped with no ack, and the SRAM strobes deassert at the reset edge.

## Timing
- VGA read: I_vga_req high in cycle c, latched at the end of c. SRAM access in c+1. O_vga_dat is valid before the end of c+1 (the requester samples at the edge ending c+1), then held until the next VGA_RD.
- SRAM access time must be ≤ clock period minus I/O delays (≤ 30 ns at 25 MHz).
- CPU access: stb seen at edge e with no VGA request -> access in cycle e..e+1 -> O_cpu_ack high in cycle e+1..e+2. Minimum latency is 1 cycle from the sampling edge.
- Write cycle: address, data and we_n all change on the same edge. we_n rises on the edge where the address may change; the SRAM must be specified for tWR=0.
- Simultaneous VGA req and CPU stb: VGA wins, and the CPU access starts at the next edge with no VGA request.

## Test plan
- **VGA read:** preload SRAM model 0x20000=0xA5, pulse I_vga_req with adr 0x20000 -> O_vga_dat=0xA5 at the edge ending the next cycle, held until the next request.
- **CPU write then read:** write 0x3C to 0x40001 -> one ack, we_n low exactly 1 cycle; then read 0x40001 -> O_cpu_dat=0x3C with ack.
- **Collision:** VGA req and CPU read asserted in the same cycle -> VGA_RD first, CPU_RD next cycle, ack 1 cycle later than the uncontended case.
- **Held stb:** hold I_cpu_stb 5 cycles after ack -> exactly one SRAM access and one ack.
- **Scan-out load:** VGA req every other cycle for 640 cycles with CPU stb continuously re-asserted -> no VGA data error, every CPU access acked within 2 cycles.
- **Reset:** assert I_reset during CPU_WR -> no ack, we_n=1, oe_n=1, ce_n=1, dat_oe=0 after the edge; normal operation resumes after release.
